// File: rtl/vlc_output_scheduler_pkg.sv
// Shared types and constants for the VLC output scheduler: codeword and size
// widths, the FIFO entry layout and the slice phase enum.
package vlc_pkg;

   localparam int CODE_W  = 64;
   localparam int SIZE_W  = 7;
   localparam int ENTRY_W = CODE_W + SIZE_W;

   typedef enum logic {
      DC_PHASE = 1'b0,
      AC_PHASE = 1'b1
   } state_t;

   typedef struct packed {
      logic [CODE_W-1:0] val;
      logic [SIZE_W-1:0] size;
   } entry_t;

   // Codeword lengths travel as 7 bits internally and leave zero-extended.
   function automatic logic [CODE_W-1:0] size_extend(input logic [SIZE_W-1:0] size);
      return {{(CODE_W - SIZE_W){1'b0}}, size};
   endfunction

endpackage

// File: rtl/vlc_output_scheduler_if.sv
// Bundle of the DC/AC VLC input streams and the codeword stream to the bit packer.
// The scheduler takes the slave view; the VLC stages and packer form the master view.
interface vlc_output_scheduler_if;
   import vlc_pkg::*;

   logic              dc_enable;
   logic [CODE_W-1:0] dc_val;
   logic [CODE_W-1:0] dc_size_of_bit;
   logic              dc_flush;
   logic              ac_enable;
   logic [CODE_W-1:0] ac_val;
   logic [CODE_W-1:0] ac_size_of_bit;
   logic              ac_flush;
   logic              output_enable;
   logic [CODE_W-1:0] val;
   logic [CODE_W-1:0] size_of_bit;
   logic              flush_bit;
   logic              overflow;
   logic              seq_error;

   modport slave (
      input  dc_enable, dc_val, dc_size_of_bit, dc_flush,
      input  ac_enable, ac_val, ac_size_of_bit, ac_flush,
      output output_enable, val, size_of_bit, flush_bit, overflow, seq_error
   );

   modport master (
      output dc_enable, dc_val, dc_size_of_bit, dc_flush,
      output ac_enable, ac_val, ac_size_of_bit, ac_flush,
      input  output_enable, val, size_of_bit, flush_bit, overflow, seq_error
   );

endinterface

// File: rtl/vlc_output_scheduler_sync_fifo.sv
// Synchronous FIFO holding AC codewords while the DC section is open.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// read data is registered and updates only on an accepted pop.
module vlc_sync_fifo #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 71
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             wr_ok_s;
   logic             rd_ok_s;

   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign wr_ok_s = push && (!full || pop);
   assign rd_ok_s = pop && !empty;

   // Advance the write and read pointers on accepted transfers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
         end
         if (rd_ok_s) begin
            rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
         end
      end
   end

   // Storage array; contents need no reset because the pointers gate validity.
   always_ff @(posedge clock) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
      end
   end

   // Register the head entry as it is popped.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data <= '0;
      end else if (rd_ok_s) begin
         rd_data <= mem_r[rd_ptr_r[AW-1:0]];
      end
   end

endmodule

// File: rtl/vlc_output_scheduler.sv
// Merges the DC and AC VLC streams of a slice into one codeword stream:
// DC words pass straight through, AC words are buffered until the DC section
// closes and then drained one per cycle, and a flush pulse ends the slice.
module vlc_output_scheduler
   import vlc_pkg::*;
#(
   parameter int FIFO_DEPTH = 64
) (
   input logic                   clock,
   input logic                   reset_n,
   vlc_output_scheduler_if.slave bus
);

   state_t            state_r;
   state_t            state_next_s;
   logic              ac_done_r;
   logic              pop_valid_r;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic              dc_fwd_s;
   logic              seq_err_s;
   logic              end_slice_s;
   entry_t            wr_entry_s;
   logic [ENTRY_W-1:0] rd_bits_s;
   entry_t            rd_entry_s;
   logic              oe_next_s;
   logic [CODE_W-1:0] val_next_s;
   logic [CODE_W-1:0] size_next_s;
   logic              flush_next_s;
   logic              unused_size_bits;

   // Only the low 7 size bits are meaningful; the rest are deliberately ignored.
   assign unused_size_bits = ^{bus.dc_size_of_bit[CODE_W-1:SIZE_W],
                               bus.ac_size_of_bit[CODE_W-1:SIZE_W]};

   assign push_s      = bus.ac_enable;
   assign pop_s       = (state_r == AC_PHASE) && !fifo_empty_s;
   assign drop_s      = push_s && fifo_full_s && !pop_s;
   assign dc_fwd_s    = (state_r == DC_PHASE) && bus.dc_enable;
   assign seq_err_s   = (state_r == AC_PHASE) && (bus.dc_enable || bus.dc_flush);
   // Slice ends only once nothing is buffered, in flight to the outputs, or arriving.
   assign end_slice_s = (state_r == AC_PHASE) && ac_done_r && fifo_empty_s &&
                        !pop_valid_r && !push_s;

   assign wr_entry_s.val  = bus.ac_val;
   assign wr_entry_s.size = bus.ac_size_of_bit[SIZE_W-1:0];
   assign rd_entry_s      = entry_t'(rd_bits_s);

   vlc_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push_s),
      .wr_data (wr_entry_s),
      .pop     (pop_s),
      .rd_data (rd_bits_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // Phase sequencing: dc_flush opens the AC section, end of slice closes it.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         DC_PHASE: begin
            if (bus.dc_flush) begin
               state_next_s = AC_PHASE;
            end else begin
               state_next_s = DC_PHASE;
            end
         end
         AC_PHASE: begin
            if (end_slice_s) begin
               state_next_s = DC_PHASE;
            end else begin
               state_next_s = AC_PHASE;
            end
         end
         default: begin
            state_next_s = DC_PHASE;
         end
      endcase
   end

   // Select next output word: flush pulse, drained AC word, forwarded DC word, or zeros.
   always_comb begin
      oe_next_s    = 1'b0;
      val_next_s   = '0;
      size_next_s  = '0;
      flush_next_s = 1'b0;
      if (end_slice_s) begin
         flush_next_s = 1'b1;
      end else if (pop_valid_r) begin
         oe_next_s   = 1'b1;
         val_next_s  = rd_entry_s.val;
         size_next_s = size_extend(rd_entry_s.size);
      end else if (dc_fwd_s) begin
         oe_next_s   = 1'b1;
         val_next_s  = bus.dc_val;
         size_next_s = size_extend(bus.dc_size_of_bit[SIZE_W-1:0]);
      end else begin
         oe_next_s = 1'b0;
      end
   end

   // Control state: phase, sticky AC-done flag and the pop-in-flight marker.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= DC_PHASE;
         ac_done_r   <= 1'b0;
         pop_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         pop_valid_r <= pop_s;
         if (bus.ac_flush) begin
            ac_done_r <= 1'b1;
         end else if (end_slice_s) begin
            ac_done_r <= 1'b0;
         end
      end
   end

   // Registered outputs to the bit packer plus the sticky error flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.output_enable <= 1'b0;
         bus.val           <= '0;
         bus.size_of_bit   <= '0;
         bus.flush_bit     <= 1'b0;
         bus.overflow      <= 1'b0;
         bus.seq_error     <= 1'b0;
      end else begin
         bus.output_enable <= oe_next_s;
         bus.val           <= val_next_s;
         bus.size_of_bit   <= size_next_s;
         bus.flush_bit     <= flush_next_s;
         bus.overflow      <= bus.overflow | drop_s;
         bus.seq_error     <= bus.seq_error | seq_err_s;
      end
   end

endmodule
